// File: rtl/rv32i_pkg.sv
// Shared RV32I front-end types: fetch FSM states, the NOP encoding, and the
// IF/ID slot payload that the fetch unit produces and the decoder consumes.
package rv32i_pkg;

  localparam int unsigned XLEN = 32;

  // ADDI x0,x0,0
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
  } if_id_t;

endpackage

// File: rtl/pc_gen.sv
// Program counter for the fetch stage.
// Holds pc, produces the sequential successor with wrap at the end of the ROM,
// and classifies a redirect target as bad (misaligned or beyond the ROM).
// Ports:
//   clk, reset_n        clock, synchronous active-low reset
//   seq_en              step pc to next_pc this cycle
//   redirect_valid      load redirect_addr (if it is a good target); beats seq_en
//   redirect_addr       byte target from execute
//   pc                  current fetch address (registered)
//   pc_plus4_c          pc + 4, unwrapped (link value)
//   next_pc             sequential successor, wrapped to 0 at ROM_DEPTH*4
//   bad_target          redirect_addr is not a legal fetch address
module pc_gen
  import rv32i_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned     ROM_DEPTH = 128
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            seq_en,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_addr,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4_c,
  output logic [XLEN-1:0] next_pc,
  output logic            bad_target
);

  localparam logic [XLEN-1:0] ROM_BYTES = 32'(ROM_DEPTH * 4);

  // Add first (mod 2^32), then compare against the end of the ROM.
  assign pc_plus4_c = pc + 32'd4;
  assign next_pc    = (pc_plus4_c == ROM_BYTES) ? '0 : pc_plus4_c;

  assign bad_target = (redirect_addr[1:0] != 2'b00) ||
                      (redirect_addr[XLEN-1:2] >= 30'(ROM_DEPTH));

  // A bad redirect leaves pc untouched so instr_raddr keeps pointing somewhere legal.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pc <= RESET_PC;
    end else if (redirect_valid) begin
      if (!bad_target) pc <= redirect_addr;
    end else if (seq_en) begin
      pc <= next_pc;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage sitting directly in front of instruction_memory.
// Drives the ROM address from pc, registers the returned word into the IF/ID
// slot and hands it to the decoder with valid/ready. Redirects flush the slot;
// an illegal redirect target halts fetch and raises a sticky fault.
// Ports:
//   clk, reset_n                  clock, synchronous active-low reset
//   instr_raddr / instr_code      ROM byte address (= pc) / returned word
//   redirect_valid/redirect_addr  one-cycle redirect from execute
//   if_ready                      decoder accepts the slot this cycle
//   if_valid/if_instr/if_pc/if_pc_plus4  IF/ID slot
//   fetch_fault/fault_addr        sticky bad-target fault and its address
//   fetch_count                   number of accepted handoffs (wraps)
module instr_fetch_unit
  import rv32i_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned     ROM_DEPTH = 128,
  parameter logic [XLEN-1:0] NOP_INSTR = rv32i_pkg::NOP_INSTR
) (
  input  logic            clk,
  input  logic            reset_n,
  output logic [XLEN-1:0] instr_raddr,
  input  logic [XLEN-1:0] instr_code,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_addr,
  input  logic            if_ready,
  output logic            if_valid,
  output logic [XLEN-1:0] if_instr,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_pc_plus4,
  output logic            fetch_fault,
  output logic [XLEN-1:0] fault_addr,
  output logic [XLEN-1:0] fetch_count
);

  fetch_state_e    state;
  if_id_t          slot;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_plus4_c;
  logic [XLEN-1:0] next_pc;
  logic            bad_target;
  logic            advance;
  logic            handoff;

  assign advance = (state == RUN) && (!if_valid || if_ready);
  assign handoff = if_valid && if_ready;

  pc_gen #(
    .RESET_PC  (RESET_PC),
    .ROM_DEPTH (ROM_DEPTH)
  ) u_pc_gen (
    .clk            (clk),
    .reset_n        (reset_n),
    .seq_en         (advance),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .pc             (pc),
    .pc_plus4_c     (pc_plus4_c),
    .next_pc        (next_pc),
    .bad_target     (bad_target)
  );

  assign instr_raddr = pc;
  assign if_instr    = slot.instr;
  assign if_pc       = slot.pc;
  assign if_pc_plus4 = slot.pc_plus4;

  // FSM, IF/ID slot, fault registers and handoff counter.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= BOOT;
      if_valid    <= 1'b0;
      slot        <= '{instr: NOP_INSTR, pc: '0, pc_plus4: '0};
      fetch_fault <= 1'b0;
      fault_addr  <= '0;
      fetch_count <= '0;
    end else begin
      // A handoff in a redirect cycle is still a real handoff.
      if (handoff) fetch_count <= fetch_count + 32'd1;

      if (redirect_valid) begin
        if_valid   <= 1'b0;
        slot.instr <= NOP_INSTR;
        if (bad_target) begin
          state       <= HALT;
          fetch_fault <= 1'b1;
          fault_addr  <= redirect_addr;
        end else begin
          state       <= RUN;
          fetch_fault <= 1'b0;
        end
      end else begin
        case (state)
          BOOT: state <= RUN;
          RUN: begin
            if (advance) begin
              slot     <= '{instr: instr_code, pc: pc, pc_plus4: pc_plus4_c};
              if_valid <= 1'b1;
            end
          end
          HALT: ;
          default: state <= BOOT;
        endcase
      end
    end
  end

  // Unused here; next_pc is consumed inside pc_gen.
  logic unused_ok;
  assign unused_ok = ^next_pc;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed table, hand-written corner sequences,
// then random traffic, all checked against a cycle-level reference model.
module tb_instr_fetch_unit;

  localparam logic [31:0] NOP       = 32'h0000_0013;
  localparam int unsigned ROM_WORDS = 128;
  localparam int unsigned ROM_BYTES = ROM_WORDS * 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] instr_raddr;
  logic [31:0] instr_code;
  logic        redirect_valid;
  logic [31:0] redirect_addr;
  logic        if_ready;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus4;
  logic        fetch_fault;
  logic [31:0] fault_addr;
  logic [31:0] fetch_count;

  always #5 clk = ~clk;

  instr_fetch_unit dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .instr_raddr    (instr_raddr),
    .instr_code     (instr_code),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .if_ready       (if_ready),
    .if_valid       (if_valid),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .if_pc_plus4    (if_pc_plus4),
    .fetch_fault    (fetch_fault),
    .fault_addr     (fault_addr),
    .fetch_count    (fetch_count)
  );

  // ROM standing in for instruction_memory: combinational read.
  logic [31:0] rom [0:ROM_WORDS-1];
  assign instr_code = (instr_raddr < 32'(ROM_BYTES)) ? rom[instr_raddr[8:2]] : 32'hdead_beef;

  // Reference model state.
  logic [31:0] m_pc, m_instr, m_ipc, m_ip4, m_faddr, m_cnt;
  logic        m_valid, m_fault, m_boot, m_halt;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // Advance the model across one rising edge using the inputs now applied.
  task automatic model_edge();
    logic bad;
    if (!reset_n) begin
      m_pc = 32'h0; m_valid = 1'b0; m_instr = NOP; m_ipc = 32'h0; m_ip4 = 32'h0;
      m_fault = 1'b0; m_faddr = 32'h0; m_cnt = 32'h0; m_boot = 1'b1; m_halt = 1'b0;
    end else begin
      if (m_valid && if_ready) m_cnt = m_cnt + 1;
      if (redirect_valid) begin
        bad = (redirect_addr % 4 != 0) || (redirect_addr / 4 >= ROM_WORDS);
        m_valid = 1'b0;
        m_instr = NOP;
        m_boot  = 1'b0;
        if (bad) begin
          m_halt = 1'b1; m_fault = 1'b1; m_faddr = redirect_addr;
        end else begin
          m_halt = 1'b0; m_fault = 1'b0; m_pc = redirect_addr;
        end
      end else if (m_boot) begin
        m_boot = 1'b0;
      end else if (!m_halt && (!m_valid || if_ready)) begin
        m_instr = rom[m_pc / 4];
        m_ipc   = m_pc;
        m_ip4   = m_pc + 4;
        m_valid = 1'b1;
        m_pc    = (m_pc + 4) % ROM_BYTES;
      end
    end
  endtask

  task automatic check_model();
    chk("raddr", instr_raddr, m_pc);
    chk("valid", 32'(if_valid), 32'(m_valid));
    chk("instr", if_instr, m_instr);
    chk("fault", 32'(fetch_fault), 32'(m_fault));
    chk("fault_addr", fault_addr, m_faddr);
    chk("count", fetch_count, m_cnt);
    if (m_valid) begin
      chk("if_pc", if_pc, m_ipc);
      chk("if_pc_plus4", if_pc_plus4, m_ip4);
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check_model();
  endtask

  typedef struct {
    logic        rst_n;
    logic        rv;
    logic [31:0] ra;
    logic        rdy;
    logic        e_valid;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
    logic        e_fault;
    logic [31:0] e_cnt;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic rst_n, input logic rv, input logic [31:0] ra, input logic rdy,
                     input logic e_valid, input logic [31:0] e_pc, input logic [31:0] e_instr,
                     input logic e_fault, input logic [31:0] e_cnt);
    vec_t v;
    v = '{rst_n, rv, ra, rdy, e_valid, e_pc, e_instr, e_fault, e_cnt};
    tbl.push_back(v);
  endtask

  initial begin
    for (int i = 0; i < int'(ROM_WORDS); i++) rom[i] = $urandom;
    rom[0]  = 32'h0041_82b3;
    rom[1]  = 32'h4074_0333;
    rom[2]  = 32'h0018_18b3;
    rom[3]  = 32'h00a0_0093;
    rom[10] = 32'h01e1_0123;
    rom[13] = 32'h0021_8a13;

    reset_n = 1'b0; redirect_valid = 1'b0; redirect_addr = 32'h0; if_ready = 1'b1;

    // Reset, boot, streaming, stall at 0x8, redirect while stalled, bad then good redirect.
    for (int i = 0; i < 3; i++) add(0, 0, 0, 1, 0, 0, NOP, 0, 0);
    add(1, 0, 0,     1, 0, 0,     NOP,          0, 0);
    add(1, 0, 0,     1, 1, 32'h0, 32'h004182b3, 0, 0);
    add(1, 0, 0,     1, 1, 32'h4, 32'h40740333, 0, 1);
    add(1, 0, 0,     1, 1, 32'h8, 32'h001818b3, 0, 2);
    for (int i = 0; i < 4; i++) add(1, 0, 0, 0, 1, 32'h8, 32'h001818b3, 0, 2);
    add(1, 0, 0,      1, 1, 32'hC,  32'h00a00093, 0, 3);
    add(1, 0, 0,      0, 1, 32'hC,  32'h00a00093, 0, 3);
    add(1, 1, 32'h28, 0, 0, 0,      NOP,          0, 3);
    add(1, 0, 0,      0, 1, 32'h28, 32'h01e10123, 0, 3);
    add(1, 1, 32'h102,0, 0, 0,      NOP,          1, 3);
    add(1, 0, 0,      0, 0, 0,      NOP,          1, 3);
    add(1, 1, 32'h34, 0, 0, 0,      NOP,          0, 3);
    add(1, 0, 0,      0, 1, 32'h34, 32'h00218a13, 0, 3);

    foreach (tbl[i]) begin
      reset_n = tbl[i].rst_n; redirect_valid = tbl[i].rv;
      redirect_addr = tbl[i].ra; if_ready = tbl[i].rdy;
      step();
      chk("tbl_valid", 32'(if_valid), 32'(tbl[i].e_valid));
      chk("tbl_instr", if_instr, tbl[i].e_instr);
      chk("tbl_fault", 32'(fetch_fault), 32'(tbl[i].e_fault));
      chk("tbl_count", fetch_count, tbl[i].e_cnt);
      if (tbl[i].e_valid) begin
        chk("tbl_pc", if_pc, tbl[i].e_pc);
        chk("tbl_pc_plus4", if_pc_plus4, tbl[i].e_pc + 32'd4);
      end
      if (i >= 7 && i <= 10) chk("tbl_stall_raddr", instr_raddr, 32'hC);
    end

    // Redirect one past the last ROM word: halt with fault, pc held at 0x38.
    redirect_valid = 1'b1; redirect_addr = 32'h200; if_ready = 1'b1;
    step();
    chk("oob_fault", 32'(fetch_fault), 32'd1);
    chk("oob_fault_addr", fault_addr, 32'h200);
    redirect_valid = 1'b0;
    step();
    step();
    chk("halt_valid", 32'(if_valid), 32'd0);
    chk("halt_raddr", instr_raddr, 32'h38);

    // Reset in the middle of HALT.
    reset_n = 1'b0;
    step();
    step();
    chk("rst_valid", 32'(if_valid), 32'd0);
    chk("rst_instr", if_instr, NOP);
    chk("rst_pc", if_pc, 32'h0);
    chk("rst_pc_plus4", if_pc_plus4, 32'h0);
    chk("rst_fault", 32'(fetch_fault), 32'd0);
    chk("rst_fault_addr", fault_addr, 32'h0);
    chk("rst_count", fetch_count, 32'h0);
    chk("rst_raddr", instr_raddr, 32'h0);
    reset_n = 1'b1;
    step();
    chk("reboot_valid", 32'(if_valid), 32'd0);
    step();
    chk("restart_pc", if_pc, 32'h0);
    chk("restart_instr", if_instr, 32'h004182b3);

    // Redirect in BOOT to 0x1F8, then run across the ROM wrap.
    reset_n = 1'b0;
    step();
    reset_n = 1'b1; redirect_valid = 1'b1; redirect_addr = 32'h1F8; if_ready = 1'b1;
    step();
    chk("boot_redir_valid", 32'(if_valid), 32'd0);
    chk("boot_redir_raddr", instr_raddr, 32'h1F8);
    redirect_valid = 1'b0;
    for (int k = 1; k <= 11; k++) begin
      step();
      if (k == 1) chk("wrap_pc0", if_pc, 32'h1F8);
      if (k == 2) chk("wrap_pc1", if_pc, 32'h1FC);
      if (k == 3) chk("wrap_pc2", if_pc, 32'h000);
      if (k == 3) chk("wrap_fault", 32'(fetch_fault), 32'd0);
      if (k == 11) chk("count10", fetch_count, 32'd10);
    end

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      int r;
      reset_n  = ($urandom_range(0, 199) != 0);
      if_ready = ($urandom_range(0, 9) < 7);
      redirect_valid = !m_boot && ($urandom_range(0, 11) == 0);
      r = int'($urandom_range(0, 4));
      case (r)
        0, 1: redirect_addr = 32'($urandom_range(0, ROM_WORDS - 1)) * 32'd4;
        2:    redirect_addr = 32'($urandom_range(0, ROM_WORDS - 1)) * 32'd4 + 32'($urandom_range(1, 3));
        3:    redirect_addr = 32'($urandom_range(ROM_WORDS, 4000)) * 32'd4;
        default: redirect_addr = 32'($urandom_range(ROM_WORDS - 4, ROM_WORDS - 1)) * 32'd4;
      endcase
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
